// File: rtl/countdown_mmss_timer.sv
// MM:SS countdown timer for the alarm clock's snooze / kitchen-timer feature.
// Loads a clamped BCD time, counts down one second per Tick with borrow
// across digits, rings on reaching 00:00 until acknowledged or timed out.
module countdown_mmss_timer #(
    parameter int RING_CYCLES = 60
) (
    input  logic       Clr,
    input  logic       Clk,
    input  logic       Tick,
    input  logic       LD,
    input  logic [2:0] IN_M1,
    input  logic [3:0] IN_M0,
    input  logic [2:0] IN_S1,
    input  logic [3:0] IN_S0,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Ack,
    output logic [2:0] M1,
    output logic [3:0] M0,
    output logic [2:0] S1,
    output logic [3:0] S0,
    output logic       Running,
    output logic       Ring,
    output logic       Done
);

    localparam int CNT_W = $clog2(RING_CYCLES + 1);
    localparam logic [CNT_W-1:0] RING_MAX = CNT_W'(RING_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_RING
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       m1_q, m1_d;
    logic [3:0]       m0_q, m0_d;
    logic [2:0]       s1_q, s1_d;
    logic [3:0]       s0_q, s0_d;
    logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
    logic             running_q, running_d;
    logic             ring_q, ring_d;
    logic             done_q, done_d;

    // Decremented digit set and borrow chain
    logic [2:0]       dec_m1, dec_s1;
    logic [3:0]       dec_m0, dec_s0;
    logic             borrow_s1, borrow_m0, borrow_m1;
    logic             count_zero, count_one;
    logic [CNT_W-1:0] ring_cnt_inc;

    // Saturate tens digits to 5 (0-5 range of a minutes/seconds tens digit)
    function automatic logic [2:0] clamp_tens(input logic [2:0] v);
        return (v > 3'd5) ? 3'd5 : v;
    endfunction

    // Saturate units digits to 9 (BCD range)
    function automatic logic [3:0] clamp_units(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    // One-second decrement with BCD borrow; never evaluated at 00:00 in RUN
    always_comb begin
        borrow_s1 = (s0_q == 4'd0);
        borrow_m0 = borrow_s1 && (s1_q == 3'd0);
        borrow_m1 = borrow_m0 && (m0_q == 4'd0);
        dec_s0    = borrow_s1 ? 4'd9 : s0_q - 4'd1;
        dec_s1    = borrow_s1 ? ((s1_q == 3'd0) ? 3'd5 : s1_q - 3'd1) : s1_q;
        dec_m0    = borrow_m0 ? ((m0_q == 4'd0) ? 4'd9 : m0_q - 4'd1) : m0_q;
        dec_m1    = borrow_m1 ? m1_q - 3'd1 : m1_q;
        count_zero = (m1_q == 3'd0) && (m0_q == 4'd0) && (s1_q == 3'd0) && (s0_q == 4'd0);
        count_one  = (m1_q == 3'd0) && (m0_q == 4'd0) && (s1_q == 3'd0) && (s0_q == 4'd1);
        ring_cnt_inc = ring_cnt_q + CNT_W'(1);
    end

    // Next-state logic: LD > Stop > Start > Tick, outputs derived from next state
    always_comb begin
        state_d    = state_q;
        m1_d       = m1_q;
        m0_d       = m0_q;
        s1_d       = s1_q;
        s0_d       = s0_q;
        ring_cnt_d = ring_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                if (LD) begin
                    m1_d = clamp_tens(IN_M1);
                    m0_d = clamp_units(IN_M0);
                    s1_d = clamp_tens(IN_S1);
                    s0_d = clamp_units(IN_S0);
                end else if (!Stop && Start) begin
                    // A paused timer at 00:00 has nothing left to run
                    state_d = count_zero ? ST_IDLE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (Stop) begin
                    state_d = ST_PAUSE;
                end else if (Tick) begin
                    m1_d = dec_m1;
                    m0_d = dec_m0;
                    s1_d = dec_s1;
                    s0_d = dec_s0;
                    if (count_one) begin
                        state_d    = ST_RING;
                        ring_cnt_d = '0;
                        done_d     = 1'b1;
                    end
                end
            end
            ST_RING: begin
                m1_d = 3'd0;
                m0_d = 4'd0;
                s1_d = 3'd0;
                s0_d = 4'd0;
                if (Ack) begin
                    state_d = ST_IDLE;
                end else if (Tick) begin
                    ring_cnt_d = ring_cnt_inc;
                    if (ring_cnt_inc == RING_MAX) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_RUN);
        ring_d    = (state_d == ST_RING);
    end

    // State, digit and output registers with asynchronous active-low clear
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q    <= ST_IDLE;
            m1_q       <= 3'd0;
            m0_q       <= 4'd0;
            s1_q       <= 3'd0;
            s0_q       <= 4'd0;
            ring_cnt_q <= '0;
            running_q  <= 1'b0;
            ring_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m1_q       <= m1_d;
            m0_q       <= m0_d;
            s1_q       <= s1_d;
            s0_q       <= s0_d;
            ring_cnt_q <= ring_cnt_d;
            running_q  <= running_d;
            ring_q     <= ring_d;
            done_q     <= done_d;
        end
    end

    assign M1      = m1_q;
    assign M0      = m0_q;
    assign S1      = s1_q;
    assign S0      = s0_q;
    assign Running = running_q;
    assign Ring    = ring_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_countdown_mmss_timer.sv
// Self-checking bench for countdown_mmss_timer: directed scenarios followed by
// randomized traffic, all compared against a seconds-based reference model.
module tb_countdown_mmss_timer;

    localparam int RC = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_RING  = 3;

    logic       Clr, Clk, Tick, LD, Start, Stop, Ack;
    logic [2:0] IN_M1, IN_S1;
    logic [3:0] IN_M0, IN_S0;
    logic [2:0] M1, S1;
    logic [3:0] M0, S0;
    logic       Running, Ring, Done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: remaining time as plain seconds
    int m_secs;
    int m_mode;
    int m_ring_ticks;
    bit m_done;

    countdown_mmss_timer #(.RING_CYCLES(RC)) dut (
        .Clr(Clr), .Clk(Clk), .Tick(Tick), .LD(LD),
        .IN_M1(IN_M1), .IN_M0(IN_M0), .IN_S1(IN_S1), .IN_S0(IN_S0),
        .Start(Start), .Stop(Stop), .Ack(Ack),
        .M1(M1), .M0(M0), .S1(S1), .S0(S0),
        .Running(Running), .Ring(Ring), .Done(Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] bcd(input int mm, input int ss);
        logic [13:0] r;
        r[13:11] = 3'(mm / 10);
        r[10:7]  = 4'(mm % 10);
        r[6:4]   = 3'(ss / 10);
        r[3:0]   = 4'(ss % 10);
        return r;
    endfunction

    function automatic logic [13:0] digits();
        return {M1, M0, S1, S0};
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_secs = 0;
        m_mode = M_IDLE;
        m_ring_ticks = 0;
        m_done = 1'b0;
    endtask

    // Advance the reference model by one clock edge using the applied inputs
    task automatic model_step();
        m_done = 1'b0;
        case (m_mode)
            M_IDLE, M_PAUSE: begin
                if (LD) begin
                    m_secs = (min_i(int'(IN_M1), 5) * 10 + min_i(int'(IN_M0), 9)) * 60
                           + min_i(int'(IN_S1), 5) * 10 + min_i(int'(IN_S0), 9);
                end else if (Stop) begin
                    m_mode = m_mode;
                end else if (Start) begin
                    m_mode = (m_secs != 0) ? M_RUN : M_IDLE;
                end
            end
            M_RUN: begin
                if (Stop) begin
                    m_mode = M_PAUSE;
                end else if (Tick) begin
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin
                        m_mode = M_RING;
                        m_ring_ticks = 0;
                        m_done = 1'b1;
                    end
                end
            end
            default: begin
                if (Ack) begin
                    m_mode = M_IDLE;
                end else if (Tick) begin
                    m_ring_ticks++;
                    if (m_ring_ticks == RC) m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".digits"}, 32'(digits()), 32'(bcd(m_secs / 60, m_secs % 60)));
        chk({tag, ".running"}, 32'(Running), 32'(m_mode == M_RUN));
        chk({tag, ".ring"}, 32'(Ring), 32'(m_mode == M_RING));
        chk({tag, ".done"}, 32'(Done), 32'(m_done));
    endtask

    // One clock: inputs already applied, step model at the edge, compare after it
    task automatic step(input string tag);
        @(posedge Clk);
        model_step();
        #1;
        check_outputs(tag);
        LD = 1'b0; Start = 1'b0; Stop = 1'b0; Tick = 1'b0; Ack = 1'b0;
    endtask

    task automatic load(input int m1, input int m0, input int s1, input int s0, input string tag);
        IN_M1 = 3'(m1); IN_M0 = 4'(m0); IN_S1 = 3'(s1); IN_S0 = 4'(s0);
        LD = 1'b1;
        step(tag);
    endtask

    task automatic start(input string tag);
        Start = 1'b1;
        step(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            Tick = 1'b1;
            step(tag);
        end
    endtask

    // Pull Clr low between edges and check the outputs clear before the next edge
    task automatic async_reset(input string tag);
        #2;
        Clr = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        #1;
        Clr = 1'b1;
    endtask

    initial begin
        Clr = 1'b0; Tick = 1'b0; LD = 1'b0; Start = 1'b0; Stop = 1'b0; Ack = 1'b0;
        IN_M1 = '0; IN_M0 = '0; IN_S1 = '0; IN_S0 = '0;
        model_reset();
        #12;
        check_outputs("reset");
        Clr = 1'b1;

        // Countdown and borrow
        load(0, 1, 3, 0, "t1_load");
        chk("t1_loaded", 32'(digits()), 32'(bcd(1, 30)));
        start("t1_start");
        chk("t1_running", 32'(Running), 32'd1);
        ticks(1, "t1_tick");
        chk("t1_0129", 32'(digits()), 32'(bcd(1, 29)));
        ticks(29, "t1_tick29");
        chk("t1_0100", 32'(digits()), 32'(bcd(1, 0)));
        ticks(1, "t1_borrow");
        chk("t1_0059", 32'(digits()), 32'(bcd(0, 59)));
        chk("t1_still_running", 32'(Running), 32'd1);

        // Expiry and Ack
        Stop = 1'b1;
        step("t2_pause");
        load(0, 0, 0, 3, "t2_load");
        start("t2_start");
        ticks(3, "t2_tick");
        chk("t2_done", 32'(Done), 32'd1);
        chk("t2_ring", 32'(Ring), 32'd1);
        chk("t2_not_running", 32'(Running), 32'd0);
        step("t2_after");
        chk("t2_done_once", 32'(Done), 32'd0);
        ticks(2, "t2_ring_hold");
        chk("t2_zero_held", 32'(digits()), 32'(bcd(0, 0)));
        Ack = 1'b1;
        step("t2_ack");
        chk("t2_ring_off", 32'(Ring), 32'd0);
        start("t2_idle_start");
        chk("t2_idle_stays", 32'(Running), 32'd0);

        // Ring timeout
        load(0, 0, 0, 1, "t3_load");
        start("t3_start");
        ticks(1, "t3_expire");
        ticks(3, "t3_ring_ticks");
        chk("t3_ring_after3", 32'(Ring), 32'd1);
        ticks(1, "t3_timeout");
        chk("t3_ring_after4", 32'(Ring), 32'd0);
        chk("t3_no_redone", 32'(Done), 32'd0);

        // Pause and reload
        load(0, 0, 1, 0, "t4_load");
        start("t4_start");
        Stop = 1'b1; Tick = 1'b1;
        step("t4_stop_tick");
        chk("t4_held", 32'(digits()), 32'(bcd(0, 10)));
        chk("t4_paused", 32'(Running), 32'd0);
        ticks(3, "t4_paused_ticks");
        chk("t4_frozen", 32'(digits()), 32'(bcd(0, 10)));
        load(0, 0, 0, 5, "t4_reload");
        chk("t4_0005", 32'(digits()), 32'(bcd(0, 5)));
        start("t4_resume");
        ticks(1, "t4_tick");
        chk("t4_0004", 32'(digits()), 32'(bcd(0, 4)));

        // Clamp, zero start, LD with Start
        Stop = 1'b1;
        step("t5_pause");
        load(7, 12, 6, 15, "t5_clamp");
        chk("t5_5959", 32'(digits()), 32'(bcd(59, 59)));
        start("t5_start");
        ticks(1, "t5_tick");
        chk("t5_5958", 32'(digits()), 32'(bcd(59, 58)));
        Stop = 1'b1;
        step("t5_pause2");
        load(0, 0, 0, 0, "t5_zero");
        start("t5_zero_start");
        chk("t5_zero_idle", 32'(Running), 32'd0);
        IN_M1 = 3'd0; IN_M0 = 4'd0; IN_S1 = 3'd0; IN_S0 = 4'd9;
        LD = 1'b1; Start = 1'b1;
        step("t5_ld_start");
        chk("t5_ld_only", 32'(Running), 32'd0);
        chk("t5_ld_value", 32'(digits()), 32'(bcd(0, 9)));

        // Async reset and ignored load
        load(0, 2, 0, 0, "t6_load");
        start("t6_start");
        load(0, 0, 0, 7, "t6_ld_in_run");
        chk("t6_ld_ignored", 32'(digits()), 32'(bcd(2, 0)));
        async_reset("t6_reset_run");
        chk("t6_reset_digits", 32'(digits()), 32'(bcd(0, 0)));
        load(0, 0, 0, 1, "t6_load1");
        start("t6_start1");
        ticks(1, "t6_expire");
        chk("t6_ringing", 32'(Ring), 32'd1);
        async_reset("t6_reset_ring");
        chk("t6_ring_cleared", 32'(Ring), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            LD    = ($urandom_range(0, 99) < 6);
            Start = ($urandom_range(0, 99) < 12);
            Stop  = ($urandom_range(0, 99) < 5);
            Ack   = ($urandom_range(0, 99) < 5);
            Tick  = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 1) == 0) begin
                IN_M1 = 3'd0;
                IN_M0 = 4'd0;
                IN_S1 = 3'($urandom_range(0, 1));
                IN_S0 = 4'($urandom_range(0, 15));
            end else begin
                IN_M1 = 3'($urandom_range(0, 7));
                IN_M0 = 4'($urandom_range(0, 15));
                IN_S1 = 3'($urandom_range(0, 7));
                IN_S0 = 4'($urandom_range(0, 15));
            end
            step("rand");
            if (c % 700 == 699) async_reset("rand_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_mmss_timer.md
Name: countdown_mmss_timer

Overview:
- Settable MM:SS down-counter for the snooze/kitchen-timer feature of the alarm clock.
- Complement of the up-counting 0-5/0-9 time digits: loads a BCD time, counts down once per Tick strobe with borrow across digits, and raises Ring on reaching 00:00.
- Sits beside the clock-time counters. Takes the 1 Hz Tick from the shared prescaler and drives the display mux and the buzzer logic.

Parameters:
- RING_CYCLES, default 60: number of Tick strobes Ring stays asserted if not acknowledged.

Ports:
- Clr  in  1  asynchronous reset, active-low
- Clk  in  1  clock, rising edge
- Tick  in  1  one-Clk-cycle strobe per second
- LD  in  1  synchronous load, active-high
- IN_M1  in  3  load value, minutes tens
- IN_M0  in  4  load value, minutes units
- IN_S1  in  3  load value, seconds tens
- IN_S0  in  4  load value, seconds units
- Start  in  1  begin or resume countdown, level-sampled
- Stop  in  1  pause countdown, level-sampled
- Ack  in  1  silence Ring
- M1  out  3  minutes tens, 0-5
- M0  out  4  minutes units, 0-9
- S1  out  3  seconds tens, 0-5
- S0  out  4  seconds units, 0-9
- Running  out  1  high while in RUN
- Ring  out  1  high while in RING
- Done  out  1  one-cycle pulse on expiry

Behaviour:
- Reset:
  - Clr low forces, immediately and independent of Clk: digits 00:00, state IDLE, Running=0, Ring=0, Done=0, ring counter 0.
  - Applies in any state, including mid-RUN and mid-RING.
- States: IDLE, RUN, PAUSE, RING. All outputs are registered.
- Load:
  - Accepted only in IDLE or PAUSE; ignored in RUN and RING.
  - Loaded value is visible the cycle after the LD edge.
  - Clamping: IN_S0 or IN_M0 > 9 loads 9; IN_S1 or IN_M1 > 5 loads 5.
- Priority within one cycle: Clr > LD > Stop > Start > Tick.
  - LD and Start together in IDLE/PAUSE: load only; Start is ignored that cycle.
- IDLE:
  - Start with count != 00:00 -> RUN.
  - Start with 00:00 -> stays IDLE.
- RUN:
  - Stop -> PAUSE. A Tick in the same cycle is discarded (no decrement).
  - Start is ignored.
  - Tick without Stop decrements the count at that edge:
    - S0 decrements; 0 -> 9 with borrow into S1.
    - S1: 0 -> 5 with borrow into M0.
    - M0: 0 -> 9 with borrow into M1.
    - M1 decrements.
  - Decrement from 00:01 to 00:00 -> RING at the same edge. Done=1 for exactly the following cycle, Ring=1, Running=0.
- PAUSE:
  - Digits frozen; Ticks ignored.
  - Start with count != 00:00 -> RUN.
  - Start with 00:00 -> IDLE.
- RING:
  - Digits held at 00:00.
  - Ack -> IDLE next edge; Ring drops. Ack in any other state is ignored.
  - Each Tick increments the ring counter (width clog2(RING_CYCLES+1)). On the RING_CYCLES-th Tick -> IDLE with Ring=0.
  - Ack and the final Tick in the same cycle -> IDLE (same result).
  - Ring counter clears on entry to RING.
- Never wraps below 00:00. 59:59 is the maximum count.

Test Plan:
1. Countdown and borrow: reset, load 01:30, Start; 1 Tick -> 01:29; 29 more -> 01:00; 1 more -> 00:59; Running=1 throughout.
2. Expiry and Ack: load 00:03, Start, 3 Ticks -> 00:00. Done high exactly 1 cycle, Ring=1, Running=0. Further Ticks leave 00:00. Ack -> Ring=0, state IDLE.
3. Ring timeout (RING_CYCLES=4): expire from 00:01 with no Ack; Ring stays 1 through Ticks 1-3 and drops after Tick 4; Done does not re-pulse.
4. Pause and reload: running at 00:10, assert Stop and Tick in the same cycle -> stays 00:10, Running=0. Three Ticks -> no change. LD 00:05 -> 00:05. Start, 1 Tick -> 00:04.
5. Clamp and zero start: load M1=7, M0=12, S1=6, S0=15 -> 59:59; Start, Tick -> 59:58. Separately, load 00:00, Start -> stays IDLE, Running=0.
6. Async reset and ignored load: in RUN at 02:00, pulse LD with 00:07 -> still 02:00. Drop Clr between Clk edges -> 00:00, Running=0 before the next edge. In RING, drop Clr -> Ring=0 immediately.
